// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, block geometry,
// the padding marker and the initial hash value used by the core.
package sha256_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_ISSUE,
      ST_WAIT_CLR,
      ST_WAIT_DONE,
      ST_EXTRA,
      ST_OUT
   } state_t;

   localparam int         BLOCK_WORDS = 16;
   localparam int         LEN_WORD_HI = 14;
   localparam logic [7:0] PAD_BYTE    = 8'h80;

   localparam logic [31:0] H0 = 32'h6a09e667;
   localparam logic [31:0] H1 = 32'hbb67ae85;
   localparam logic [31:0] H2 = 32'h3c6ef372;
   localparam logic [31:0] H3 = 32'ha54ff53a;
   localparam logic [31:0] H4 = 32'h510e527f;
   localparam logic [31:0] H5 = 32'h9b05688c;
   localparam logic [31:0] H6 = 32'h1f83d9ab;
   localparam logic [31:0] H7 = 32'h5be0cd19;
   localparam logic [255:0] IV = {H0, H1, H2, H3, H4, H5, H6, H7};

   // Byte count of a final word; 0 and anything above 4 mean a full word.
   function automatic logic [2:0] norm_bytes(input logic [2:0] b);
      return ((b == 3'd0) || (b > 3'd4)) ? 3'd4 : b;
   endfunction

endpackage

// File: rtl/sha256_stream_ctrl_pad.sv
// Final-word padding: keeps the valid leading bytes, zeroes the rest and
// places the 0x80 marker right after the last valid byte. A full word has
// no room for the marker, which is flagged as a spill into the next word.
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  nbytes,
   output logic [31:0] padded,
   output logic        spill
);

   logic [2:0] n;

   // Mask and marker insertion selected by the normalized byte count.
   always_comb begin
      n     = norm_bytes(nbytes);
      spill = (n == 3'd4);
      case (n)
         3'd1:    padded = {word[31:24], PAD_BYTE, 16'h0000};
         3'd2:    padded = {word[31:16], PAD_BYTE, 8'h00};
         3'd3:    padded = {word[31:8], PAD_BYTE};
         default: padded = word;
      endcase
   end

endmodule

// File: rtl/sha256_stream_ctrl.sv
// Streaming SHA-256 front end: packs 32-bit message words into 512-bit
// blocks, pads and appends the bit length, sequences the core block by
// block with hash chaining, and returns the digest on a valid/ready port.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | no message in progress, waiting for the first word
// ST_FILL      | accepting message words into the block buffer
// ST_ISSUE     | one-cycle start pulse to the core
// ST_WAIT_CLR  | waiting for the core to drop its stale done flag
// ST_WAIT_DONE | waiting for the core to finish the current block
// ST_EXTRA     | building the trailing padding/length-only block
// ST_OUT       | digest held valid until accepted
module sha256_stream_ctrl
   import sha256_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   input  logic [2:0]   s_bytes,
   output logic         d_valid,
   input  logic         d_ready,
   output logic [255:0] digest,
   output logic         busy,
   output logic         core_start,
   output logic [511:0] core_block,
   output logic [255:0] core_hash_init,
   output logic         core_use_init,
   input  logic [255:0] core_hash_out,
   input  logic         core_ready
);

   state_t           state, state_nxt;
   logic [3:0]       widx;
   logic [LEN_W-1:0] byte_cnt;
   logic             first, fin, extra, extra80;
   logic [511:0]     blk;
   logic [255:0]     digest_q;
   logic [31:0]      pad_data;
   logic             pad_spill;
   logic [LEN_W-1:0] cnt_add, cnt_nxt;
   logic [4:0]       nxt_free;
   logic [63:0]      len_fill, len_extra;

   sha256_pad_word u_pad (
      .word   (s_data),
      .nbytes (s_bytes),
      .padded (pad_data),
      .spill  (pad_spill)
   );

   assign cnt_add   = s_last ? LEN_W'(norm_bytes(s_bytes)) : LEN_W'(4);
   assign cnt_nxt   = byte_cnt + cnt_add;
   assign nxt_free  = {1'b0, widx} + (pad_spill ? 5'd2 : 5'd1);
   assign len_fill  = 64'({cnt_nxt, 3'b000});
   assign len_extra = 64'({byte_cnt, 3'b000});

   assign core_block     = blk;
   assign core_hash_init = core_hash_out;
   assign core_use_init  = ~first;
   assign digest         = digest_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake/strobe outputs.
   always_comb begin
      state_nxt  = state;
      s_ready    = 1'b0;
      d_valid    = 1'b0;
      core_start = 1'b0;
      busy       = (state != ST_IDLE);
      case (state)
         ST_IDLE:      if (s_valid) state_nxt = ST_FILL;
         ST_FILL: begin
            s_ready = 1'b1;
            if (s_valid && (s_last || (widx == 4'd15))) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            core_start = 1'b1;
            state_nxt  = ST_WAIT_CLR;
         end
         ST_WAIT_CLR:  if (!core_ready) state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (core_ready) state_nxt = fin ? ST_OUT : (extra ? ST_EXTRA : ST_FILL);
         ST_EXTRA:     state_nxt = ST_ISSUE;
         ST_OUT: begin
            d_valid = 1'b1;
            if (d_ready) state_nxt = ST_IDLE;
         end
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Block buffer, counters, message flags and digest capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         widx     <= '0;
         byte_cnt <= '0;
         first    <= 1'b1;
         fin      <= 1'b0;
         extra    <= 1'b0;
         extra80  <= 1'b0;
         blk      <= '0;
         digest_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (s_valid) begin
               widx     <= '0;
               byte_cnt <= '0;
               first    <= 1'b1;
               fin      <= 1'b0;
               extra    <= 1'b0;
               extra80  <= 1'b0;
            end
            ST_FILL: if (s_valid) begin
               byte_cnt <= cnt_nxt;
               widx     <= widx + 4'd1;
               if (!s_last) begin
                  blk[511-32*int'(widx) -: 32] <= s_data;
                  fin   <= 1'b0;
                  extra <= 1'b0;
               end else begin
                  for (int i = 0; i < BLOCK_WORDS; i++) begin
                     if (i == int'(widx))
                        blk[511-32*i -: 32] <= pad_data;
                     else if (i > int'(widx))
                        blk[511-32*i -: 32] <= (pad_spill && (i == int'(widx) + 1)) ?
                                               {PAD_BYTE, 24'h0} : 32'h0;
                  end
                  if (nxt_free <= 5'(LEN_WORD_HI)) begin
                     blk[511-32*LEN_WORD_HI -: 64] <= len_fill;
                     fin     <= 1'b1;
                     extra   <= 1'b0;
                     extra80 <= 1'b0;
                  end else begin
                     fin     <= 1'b0;
                     extra   <= 1'b1;
                     extra80 <= pad_spill && (widx == 4'd15);
                  end
               end
            end
            ST_WAIT_DONE: if (core_ready) begin
               first <= 1'b0;
               widx  <= '0;
               if (fin) digest_q <= core_hash_out;
            end
            ST_EXTRA: begin
               blk <= '0;
               blk[511 -: 32] <= extra80 ? {PAD_BYTE, 24'h0} : 32'h0;
               blk[511-32*LEN_WORD_HI -: 64] <= len_extra;
               fin   <= 1'b1;
               extra <= 1'b0;
            end
            ST_OUT: if (d_ready) digest_q <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Bench for sha256_stream_ctrl with a behavioural SHA-256 core attached to
// the core-side ports and a byte-level reference hash for expected digests.
module tb_sha256_stream_ctrl;

   typedef byte unsigned bq_t[$];

   localparam logic [255:0] SHA_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk, rst;
   logic         s_valid, s_ready, s_last;
   logic [31:0]  s_data;
   logic [2:0]   s_bytes;
   logic         d_valid, d_ready, busy;
   logic [255:0] digest;
   logic         core_start, core_use_init, core_ready;
   logic [511:0] core_block;
   logic [255:0] core_hash_init, core_hash_out;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           n_start  = 0;
   logic [511:0] blk_log [64];
   logic         uil_log [64];
   int           cm_cnt;
   logic [255:0] cm_res;

   sha256_stream_ctrl #(.LEN_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .s_last         (s_last),
      .s_bytes        (s_bytes),
      .d_valid        (d_valid),
      .d_ready        (d_ready),
      .digest         (digest),
      .busy           (busy),
      .core_start     (core_start),
      .core_block     (core_block),
      .core_hash_init (core_hash_init),
      .core_use_init  (core_use_init),
      .core_hash_out  (core_hash_out),
      .core_ready     (core_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_comp(input logic [255:0] h, input logic [511:0] b);
      logic [31:0] w [64];
      logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, bb, c, d, e, f, g, hh} = h;
      for (int i = 0; i < 64; i++) begin
         t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
         hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
      end
      return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
              h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
   endfunction

   function automatic logic [255:0] ref_sha(input bq_t m);
      bq_t          p;
      logic [63:0]  len;
      logic [511:0] b;
      logic [255:0] h;
      p   = m;
      len = 64'(m.size()) * 64'd8;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
      h = SHA_IV;
      for (int bi = 0; bi < p.size() / 64; bi++) begin
         for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[bi*64+j];
         h = sha_comp(h, b);
      end
      return h;
   endfunction

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic logic [31:0] wd(input logic [511:0] b, input int i);
      return b[511-32*i -: 32];
   endfunction

   // Behavioural core: drops ready on start, answers 20 cycles later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_ready    <= 1'b1;
         core_hash_out <= '0;
         cm_cnt        <= 0;
         cm_res        <= '0;
      end else if (core_start) begin
         core_ready <= 1'b0;
         cm_cnt     <= 20;
         cm_res     <= sha_comp(core_use_init ? core_hash_init : SHA_IV, core_block);
      end else if (cm_cnt != 0) begin
         cm_cnt <= cm_cnt - 1;
         if (cm_cnt == 1) begin
            core_ready    <= 1'b1;
            core_hash_out <= cm_res;
         end
      end
   end

   // Log each block handed to the core.
   always @(posedge clk) begin
      if (core_start && n_start < 64) begin
         blk_log[n_start] <= core_block;
         uil_log[n_start] <= core_use_init;
         n_start <= n_start + 1;
      end
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
      int t;
      s_valid = 1'b1; s_data = d; s_last = last; s_bytes = nb; t = 0;
      while (!s_ready && t < 500) begin @(negedge clk); t++; end
      chk("s_ready_wait", s_ready, 1);
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_msg(input bq_t m);
      int n, nw, rem;
      logic [31:0] d;
      n  = m.size();
      nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         d   = '0;
         rem = n - 4 * w;
         for (int k = 0; k < 4; k++) if (4 * w + k < n) d[31-8*k -: 8] = m[4*w+k];
         push_word(d, w == nw - 1, (w == nw - 1) ? ((rem >= 4) ? 3'd4 : 3'(rem)) : 3'd4);
      end
      chk("start_after_last", core_start, 1);
   endtask

   task automatic get_digest(input string tag, input logic [255:0] exp, input int hold);
      int t, bad;
      t = 0; bad = 0;
      while (!d_valid && t < 3000) begin @(negedge clk); t++; end
      chk({tag, "_dvalid"}, d_valid, 1);
      chk({tag, "_digest"}, digest, exp);
      if (hold > 0) begin
         s_valid = 1'b1; s_data = 32'hdeadbeef;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (d_valid !== 1'b1 || digest !== exp || s_ready !== 1'b0) bad++;
         end
         s_valid = 1'b0;
         chk({tag, "_hold_unstable_cycles"}, bad, 0);
      end
      d_ready = 1'b1;
      @(negedge clk);
      d_ready = 1'b0;
      chk({tag, "_dvalid_drop"}, d_valid, 0);
      if (hold > 0) begin
         chk({tag, "_digest_drop"}, digest, 0);
         chk({tag, "_busy_idle"}, busy, 0);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_d_valid"}, d_valid, 0);
      chk({tag, "_digest"}, digest, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_core_block"}, core_block, 0);
      chk({tag, "_core_use_init"}, core_use_init, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required end of test");
      $fatal(1, "timeout");
   end

   initial begin
      bq_t m_abc, m_56, m_64, m_61;
      int  base, t;

      m_abc = str2q("abc");
      m_56  = str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      for (int i = 0; i < 64; i++) m_64.push_back(8'(i));
      for (int i = 0; i < 61; i++) m_61.push_back(8'(i * 3 + 1));

      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bytes = '0; d_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst = 1'b0;
      @(negedge clk);

      // "abc": single block
      base = n_start;
      send_msg(m_abc);
      get_digest("abc", 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0);
      chk("abc_starts", n_start - base, 1);
      chk("abc_w0", wd(blk_log[base], 0), 32'h61626380);
      chk("abc_w15", wd(blk_log[base], 15), 32'h00000018);
      chk("abc_use_init", uil_log[base], 0);

      // 56 bytes: marker fits, length spills into a second block
      base = n_start;
      send_msg(m_56);
      get_digest("m56", 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 0);
      chk("m56_starts", n_start - base, 2);
      chk("m56_b0_w14", wd(blk_log[base], 14), 32'h80000000);
      chk("m56_b0_w15", wd(blk_log[base], 15), 32'h0);
      chk("m56_use_init0", uil_log[base], 0);
      chk("m56_use_init1", uil_log[base+1], 1);
      chk("m56_b1_w15", wd(blk_log[base+1], 15), 32'h000001c0);

      // 64 bytes: marker and length both in the extra block
      base = n_start;
      send_msg(m_64);
      get_digest("m64", ref_sha(m_64), 0);
      chk("m64_starts", n_start - base, 2);
      chk("m64_b0_w15", wd(blk_log[base], 15), 32'h3c3d3e3f);
      chk("m64_b1", blk_log[base+1], {32'h80000000, 416'h0, 64'h200});

      // 61 bytes: marker lands in byte 61, extra block carries only length;
      // digest is held for 10 cycles before acceptance
      base = n_start;
      send_msg(m_61);
      get_digest("m61", ref_sha(m_61), 10);
      chk("m61_starts", n_start - base, 2);
      chk("m61_b0_w15", wd(blk_log[base], 15), {m_61[60], 8'h80, 16'h0});
      chk("m61_b1_w0", wd(blk_log[base+1], 0), 32'h0);
      chk("m61_b1_w14", wd(blk_log[base+1], 14), 32'h0);
      chk("m61_b1_w15", wd(blk_log[base+1], 15), 32'h000001e8);

      // reset while the core is working on a block
      base = n_start;
      send_msg(m_abc);
      t = 0;
      while (n_start == base && t < 100) begin @(negedge clk); t++; end
      repeat (5) @(negedge clk);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outs("mid_rst");
      rst = 1'b0;
      @(negedge clk);
      send_msg(m_abc);
      get_digest("abc_after_rst", 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
